hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Parametrised successor to the single-cycle multiply unit and HI/LO register pair in the MEM stage. It is an iterative multiply/divide engine that owns the HI/LO registers and processes one bit per clock. It exposes a Start/Busy/Done handshake so the hazard detection unit can stall MFHI/MFLO and back-to-back mul/div ops. It sits beside the ALU in EX, takes forwarded RegValA/RegValB, and drives HI/LO to the MFHI/MFLO path.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each, product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH), width of the iteration counter (derived, not overridden).

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled on a Clk edge only while Busy=0
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
OperandA  input  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
OperandB  input  WIDTH  rt value (multiplier / divisor)
Busy  output  1  operation in flight; hazard unit stalls IF/ID and PC while high
Done  output  1  one-cycle pulse in the cycle after HI/LO are written
DivByZero  output  1  set with Done when the divisor was 0; cleared on the next accepted Start
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, FSM=IDLE, counter=0. Reset wins over a simultaneous Start.
- FSM states are IDLE, RUN, FIX.
- IDLE:
  - Start with MTHI/MTLO writes Hi/Lo from OperandA at that edge. Busy stays 0 and Done pulses the next cycle.
  - Start with a mul/div op latches the operands, takes magnitudes for signed ops, records the result signs, clears DivByZero and moves to RUN. Busy=1 from the next cycle.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After WIDTH edges the FSM moves to FIX.
- FIX: applies the sign correction and writes Hi/Lo, pulses Done, returns to IDLE and sets Busy=0, all at the same edge.
- Latency: Hi/Lo are updated WIDTH+1 edges after the accepting edge (33 for WIDTH=32). Busy is high for exactly WIDTH+1 cycles.
- Hi/Lo hold their old values throughout RUN. Intermediate results are never visible on Hi/Lo.
- Start while Busy=1 is ignored with no side effects. The requester holds Start until it sees Busy=0.
- Multiply result: {Hi,Lo} = full 2*WIDTH product, two's complement for MULT, unsigned for MULTU.
- Divide result: Lo = quotient truncated toward zero, Hi = remainder with the sign of the dividend.
- Divide overflow: most-negative / -1 gives Lo = most-negative and Hi = 0.
- Divide by zero: takes the full latency, then Hi = OperandA, Lo = all ones, DivByZero=1.
- Reset mid-RUN aborts the operation: no Done pulse, Hi/Lo forced to 0.
- Ops 110 and 111 without the optional feature: Start is accepted as a no-op. Busy stays 0, Done is not pulsed, Hi/Lo are unchanged.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: MADD/MSUB run the signed multiply path. At FIX, {Hi,Lo} = {Hi,Lo} ± product, modulo 2^(2*WIDTH), with the same latency as MULT.
- Undefined: no accumulate adder is synthesised, and 110/111 behave as no-ops as stated above.

Decomposition:
- Package muldiv_pkg holds:
  - the Op encoding constants (OP_MULT..OP_MSUB);
  - the FSM state typedef (IDLE/RUN/FIX);
  - the DivByZero quotient constant (all ones).
- One sub-module, muldiv_core: the per-bit shift-add/shift-subtract datapath with its accumulator and shift registers. It has no FSM; the top supplies step/load/mode strobes to it.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001, Done exactly 33 cycles after accept. Busy high 33 cycles.
- MULT -3 × 7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then DIVU 100 / 7 → Lo=14, Hi=2.
- DIV -7 / 2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIV 0x12345678 / 0 → Hi=0x12345678, Lo=0xFFFFFFFF, DivByZero=1 with Done. DivByZero is cleared by the next accepted Start.
- MULT started, a second Start (MTLO 0xAA) issued at RUN cycle 5, then Reset at RUN cycle 10 → the MTLO has no effect; next cycle Busy=0, Hi=Lo=0, no Done pulse.
- With MULDIV_MADD_EN: MTLO 5, MTHI 0, then MADD 2 × 3 → Lo=11, Hi=0. Then MSUB 4 × 4 → {Hi,Lo} = 0xFFFFFFFF_FFFFFFFB.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and the quotient reported on divide-by-zero.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

  // Wide enough for any supported WIDTH; users slice the low bits.
  localparam logic [127:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned one-bit-per-step datapath: right-shifting shift-add multiply and
// left-shifting restoring divide. {accOut,mqOut} is the product, or remainder/quotient.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             divMode,
  input  logic [WIDTH-1:0] magA,
  input  logic [WIDTH-1:0] magB,
  output logic [WIDTH-1:0] accOut,
  output logic [WIDTH-1:0] mqOut
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] operand;
  logic             divQ;

  logic [WIDTH:0] addSum;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] trialDiff;

  always_comb begin
    addSum    = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
    remShift  = {acc, mq[WIDTH-1]};
    trialDiff = remShift - {1'b0, operand};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mq      <= '0;
      operand <= '0;
      divQ    <= 1'b0;
    end else if (load) begin
      // Multiply keeps the multiplier in mq; divide keeps the dividend there.
      acc     <= '0;
      divQ    <= divMode;
      mq      <= divMode ? magA : magB;
      operand <= divMode ? magB : magA;
    end else if (step) begin
      if (divQ) begin
        if (!trialDiff[WIDTH]) begin
          acc <= trialDiff[WIDTH-1:0];
          mq  <= {mq[WIDTH-2:0], 1'b1};
        end else begin
          acc <= remShift[WIDTH-1:0];
          mq  <= {mq[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc, mq} <= {addSum, mq[WIDTH-1:1]};
      end
    end
  end

  assign accOut = acc;
  assign mqOut  = mq;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning HI/LO, with a Start/Busy/Done handshake.
// Optional macro MULDIV_MADD_EN adds MADD/MSUB accumulation into {Hi,Lo}.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  muldiv_state_e state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       opQ;
  logic             negRes, negRem, divZeroQ;
  logic [WIDTH-1:0] dividendQ;

  logic             engineOp, signedOp, divOp, aNeg, bNeg;
  logic [WIDTH-1:0] magA, magB, coreHi, coreLo;
  logic             coreLoad, coreStep;
  logic [2*WIDTH-1:0] prodSigned, result;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    divOp = (Op == OP_DIV) || (Op == OP_DIVU);
`ifdef MULDIV_MADD_EN
    signedOp = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    engineOp = (Op != OP_MTHI) && (Op != OP_MTLO);
`else
    signedOp = (Op == OP_MULT) || (Op == OP_DIV);
    engineOp = (Op == OP_MULT) || (Op == OP_MULTU) || divOp;
`endif
    aNeg = signedOp && OperandA[WIDTH-1];
    bNeg = signedOp && OperandB[WIDTH-1];
    magA = aNeg ? (~OperandA + 1'b1) : OperandA;
    magB = bNeg ? (~OperandB + 1'b1) : OperandB;
  end

  always_comb begin
    nextState = state;
    coreLoad  = 1'b0;
    coreStep  = 1'b0;
    case (state)
      IDLE: if (Start && engineOp) begin
        nextState = RUN;
        coreLoad  = 1'b1;
      end
      RUN: begin
        coreStep = 1'b1;
        if (cnt == LAST_STEP) nextState = FIX;
      end
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (Clk),
    .reset   (Reset),
    .load    (coreLoad),
    .step    (coreStep),
    .divMode (divOp),
    .magA    (magA),
    .magB    (magB),
    .accOut  (coreHi),
    .mqOut   (coreLo)
  );

  // Sign correction of the unsigned magnitudes from the core.
  always_comb begin
    prodSigned = negRes ? (~{coreHi, coreLo} + 1'b1) : {coreHi, coreLo};
    quot       = negRes ? (~coreLo + 1'b1) : coreLo;
    rem        = negRem ? (~coreHi + 1'b1) : coreHi;
    case (opQ)
      OP_DIV, OP_DIVU:
        result = divZeroQ ? {dividendQ, DIV_ZERO_QUOT[WIDTH-1:0]} : {rem, quot};
`ifdef MULDIV_MADD_EN
      OP_MADD: result = {Hi, Lo} + prodSigned;
      OP_MSUB: result = {Hi, Lo} - prodSigned;
`endif
      default: result = prodSigned;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      opQ       <= OP_MULT;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      divZeroQ  <= 1'b0;
      dividendQ <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      state <= nextState;
      Done  <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          DivByZero <= 1'b0;
          if (Op == OP_MTHI) begin
            Hi   <= OperandA;
            Done <= 1'b1;
          end else if (Op == OP_MTLO) begin
            Lo   <= OperandA;
            Done <= 1'b1;
          end else if (engineOp) begin
            cnt       <= '0;
            opQ       <= Op;
            negRes    <= aNeg ^ bNeg;
            negRem    <= aNeg;
            divZeroQ  <= divOp && (OperandB == '0);
            dividendQ <= OperandA;
          end
        end
        RUN: cnt <= cnt + 1'b1;
        FIX: begin
          {Hi, Lo}  <= result;
          DivByZero <= divZeroQ;
          Done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: expected {DivByZero,Hi,Lo} queued at Start,
// popped and compared when Done is seen; latency, Busy length and abort behaviour checked.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] opa, opb;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  logic [2*W:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Start     (start),
    .Op        (op),
    .OperandA  (opa),
    .OperandB  (opb),
    .Busy      (busy),
    .Done      (done),
    .DivByZero (dbz),
    .Hi        (hi),
    .Lo        (lo)
  );

  task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // driver + scoreboard: one op, wait (bounded) for Done, compare
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic exp_dbz,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_lat);
    int lat;
    int busy_cnt;
    logic held;
    logic [W-1:0] pre_hi, pre_lo;
    logic [2*W:0] expv;
    exp_q.push_back({exp_dbz, exp_hi, exp_lo});
    pre_hi = hi;
    pre_lo = lo;
    held = 1'b1;
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      if (hi !== pre_hi || lo !== pre_lo) held = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, 65'(done), 65'(1));
    check({tag, "_latency"}, 65'(lat), 65'(exp_lat));
    check({tag, "_busy_cycles"}, 65'(busy_cnt), 65'(exp_lat));
    check({tag, "_hilo_held"}, 65'(held), 65'(1));
    expv = exp_q.pop_front();
    check({tag, "_result"}, {dbz, hi, lo}, expv);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 65'(done), 65'(0));
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; op = 3'b000; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state", {busy, done, dbz, hi, lo}, '0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33);
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 33);
    run_op("div_zero", OP_DIV, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 33);
    check("dbz_held_idle", 65'(dbz), 65'(1));
    run_op("dbz_clear_divu", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33);
    run_op("mthi", OP_MTHI, 32'h0000_1111, 32'h0, 1'b0, 32'h0000_1111, 32'd14, 0);
    run_op("mtlo", OP_MTLO, 32'h0000_0055, 32'h0, 1'b0, 32'h0000_1111, 32'h0000_0055, 0);

`ifdef MULDIV_MADD_EN
    run_op("mtlo5", OP_MTLO, 32'd5, 32'h0, 1'b0, 32'h0000_1111, 32'd5, 0);
    run_op("mthi0", OP_MTHI, 32'd0, 32'h0, 1'b0, 32'd0, 32'd5, 0);
    run_op("madd", OP_MADD, 32'd2, 32'd3, 1'b0, 32'd0, 32'd11, 33);
    run_op("msub", OP_MSUB, 32'd4, 32'd4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 33);
    run_op("mtlo_55", OP_MTLO, 32'h0000_0055, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0055, 0);
`else
    // MADD/MSUB without the accumulator: accepted, no effect
    start = 1'b1; op = OP_MADD; opa = 32'd2; opb = 32'd3;
    @(posedge clk); #1;
    op = OP_MSUB;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy || done) seen++;
      @(posedge clk); #1;
    end
    check("madd_noop_quiet", 65'(seen), 65'(0));
    check("madd_noop_hilo", {1'b0, hi, lo}, {1'b0, 32'h0000_1111, 32'h0000_0055});
`endif

    // abort: MULT in flight, ignored MTLO at RUN cycle 5, Reset at RUN cycle 10
    start = 1'b1; op = OP_MULT; opa = 32'd3; opb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MTLO; opa = 32'h0000_00AA;
    repeat (4) @(posedge clk);
    #1;
    check("busy_ignores_start", {63'(0), busy, 1'b0}, {63'(0), 1'b1, 1'b0});
    check("mtlo_ignored_lo", 65'(lo), 65'(32'h0000_0055));
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_state", {busy, done, hi, lo}, '0);
    reset = 1'b0;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 65'(seen), 65'(0));
    check("abort_hilo_zero", {1'b0, hi, lo}, '0);

    run_op("post_abort_mult", OP_MULT, 32'd6, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 33);

    check("scoreboard_empty", 65'(exp_q.size()), 65'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
